// File: rtl/spi_burst_master_if.sv
// Command/response and SPI pin bundle for spi_burst_master.
// Latency: none, wiring only.
// Backpressure: command side is valid/ready; response is a one-cycle pulse with no ready.
interface spi_burst_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BYTES  = 4,
    parameter int NUM_CS     = 4
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [8*MAX_BYTES-1:0] cmd_wdata;
    logic [NB_W-1:0]        cmd_nbytes;
    logic                   cmd_write;
    logic [CS_W-1:0]        cmd_cs;
    logic                   abort;
    logic                   busy;
    logic                   rsp_valid;
    logic                   rsp_aborted;
    logic [8*MAX_BYTES-1:0] rsp_rdata;
    logic                   spi_sclk;
    logic                   spi_mosi;
    logic                   spi_miso;
    logic [NUM_CS-1:0]      spi_cs_n;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_nbytes, cmd_write, cmd_cs, abort, spi_miso,
        output cmd_ready, busy, rsp_valid, rsp_aborted, rsp_rdata, spi_sclk, spi_mosi, spi_cs_n
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_nbytes, cmd_write, cmd_cs, abort, spi_miso,
        input  cmd_ready, busy, rsp_valid, rsp_aborted, rsp_rdata, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: address phase then 1..MAX_BYTES full-duplex data bytes.
// Latency: rsp_valid at accept + 1 + (2*(ADDR_WIDTH+8n)+1)*CLK_DIV cycles.
// Backpressure: cmd_ready only in IDLE, no queuing; abort ends a transfer on the edge it is seen.
module spi_burst_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BYTES  = 4,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    spi_burst_master_if.master bus
);
    localparam int DW    = 8 * MAX_BYTES;
    localparam int TW    = ADDR_WIDTH + DW;
    localparam int NB_W  = $clog2(MAX_BYTES + 1);
    localparam int BC_W  = $clog2(TW + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BC_W-1:0]   bits_left;
    logic [BC_W-1:0]   data_bits;
    logic [TW-1:0]     tx_sr;
    logic [DW-1:0]     rx_sr;
    logic              launched;
    logic [NUM_CS-1:0] cs_sel;
    logic              sclk_q;
    logic              mosi_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic              rsp_valid_q;
    logic              rsp_aborted_q;
    logic [DW-1:0]     rdata_q;

    logic [NB_W-1:0]   n_clamped;
    logic [DW-1:0]     wdata_aligned;
    logic [NUM_CS-1:0] cs_dec;

    assign n_clamped = (bus.cmd_nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.cmd_nbytes;

    // Left-align the n payload bytes so the shifter always drains from its MSB.
    always_comb begin
        wdata_aligned = '0;
        if (bus.cmd_write) begin
            wdata_aligned = bus.cmd_wdata << (DW - 8 * int'(n_clamped));
        end
    end

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(bus.cmd_cs) == i) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bits_left     <= '0;
            data_bits     <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            launched      <= 1'b0;
            cs_sel        <= '1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            cs_n_q        <= '1;
            rsp_valid_q   <= 1'b0;
            rsp_aborted_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_aborted_q <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state         <= S_IDLE;
                sclk_q        <= 1'b0;
                mosi_q        <= 1'b0;
                cs_n_q        <= '1;
                rsp_valid_q   <= 1'b1;
                rsp_aborted_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_valid) begin
                            state     <= S_SETUP;
                            launched  <= 1'b0;
                            div_cnt   <= '0;
                            tx_sr     <= {bus.cmd_addr, wdata_aligned};
                            rx_sr     <= '0;
                            bits_left <= BC_W'(ADDR_WIDTH) + BC_W'(8 * int'(n_clamped));
                            data_bits <= BC_W'(8 * int'(n_clamped));
                            cs_sel    <= cs_dec;
                        end
                    end
                    S_SETUP: begin
                        // First SETUP cycle only drives CS and the first bit; the CLK_DIV count starts after.
                        if (!launched) begin
                            launched <= 1'b1;
                            cs_n_q   <= cs_sel;
                            mosi_q   <= tx_sr[TW-1];
                            tx_sr    <= tx_sr << 1;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            sclk_q  <= 1'b1;
                            state   <= S_SHIFT;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            sclk_q  <= ~sclk_q;
                            if (sclk_q) begin
                                if (bits_left <= data_bits) begin
                                    rx_sr <= {rx_sr[DW-2:0], bus.spi_miso};
                                end
                                mosi_q    <= tx_sr[TW-1];
                                tx_sr     <= tx_sr << 1;
                                bits_left <= bits_left - 1'b1;
                                if (bits_left == BC_W'(1)) begin
                                    state <= S_HOLD;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (div_cnt == DIV_LAST) begin
                            state       <= S_IDLE;
                            cs_n_q      <= '1;
                            mosi_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= rx_sr;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_aborted = rsp_aborted_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.spi_sclk    = sclk_q;
    assign bus.spi_mosi    = mosi_q;
    assign bus.spi_cs_n    = cs_n_q;
endmodule
